rc5_key_expand: RTL and testbench

RC5_KEY_EXPAND -- requirements
Module: rc5_key_expand

---
 rtl/rc5_key_expand_pkg.sv | 51 +++++
 rtl/rc5_key_expand_if.sv | 23 ++
 rtl/rc5_mix_step.sv | 28 ++
 rtl/rc5_key_expand.sv | 134 +++++++++++++
 tb/tb_rc5_key_expand.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc5_key_expand_pkg.sv
// Shared definitions for the RC5 key expansion block: controller states,
// the magic P/Q constants for each legal word width and a rotate helper.
package rc5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } rc5State_e;

  localparam logic [63:0] P16 = 64'h0000_0000_0000_B7E1;
  localparam logic [63:0] Q16 = 64'h0000_0000_0000_9E37;
  localparam logic [63:0] P32 = 64'h0000_0000_B7E1_5163;
  localparam logic [63:0] Q32 = 64'h0000_0000_9E37_79B9;
  localparam logic [63:0] P64 = 64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] Q64 = 64'h9E37_79B9_7F4A_7C15;

  // P constant for a given word width, zero-extended to 64 bits
  function automatic logic [63:0] pConst(input int w);
    case (w)
      16:      return P16;
      32:      return P32;
      default: return P64;
    endcase
  endfunction

  // Q constant for a given word width, zero-extended to 64 bits
  function automatic logic [63:0] qConst(input int w);
    case (w)
      16:      return Q16;
      32:      return Q32;
      default: return Q64;
    endcase
  endfunction

  // Rotate the low w bits of x left; only the low log2(w) bits of amt count
  function automatic logic [63:0] rotl(input logic [63:0] x,
                                       input logic [63:0] amt,
                                       input int          w);
    logic [63:0] mask;
    int          r;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    r    = int'(amt & 64'(w - 1));
    if (r == 0) begin
      return x & mask;
    end
    return ((x << r) | (x >> (w - r))) & mask;
  endfunction

endpackage

// File: rtl/rc5_key_expand_if.sv
// Request/result bundle between a key-expansion user and the expander.
interface rc5_key_expand_if #(
  parameter int W = 32,
  parameter int T = 26,
  parameter int C = 4
);
  logic           start;
  logic [C*W-1:0] key;
  logic           busy;
  logic           done;
  logic           s_valid;
  logic [T*W-1:0] s_out;

  modport master (
    output start, key,
    input  busy, done, s_valid, s_out
  );

  modport slave (
    input  start, key,
    output busy, done, s_valid, s_out
  );
endinterface

// File: rtl/rc5_mix_step.sv
// One combinational RC5 mixing step: new A from S[i], new B from L[j].
module rc5_mix_step
  import rc5_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] aIn,
  input  logic [W-1:0] bIn,
  input  logic [W-1:0] sIn,
  input  logic [W-1:0] lIn,
  output logic [W-1:0] aOut,
  output logic [W-1:0] bOut
);

  logic [W-1:0] sum1;
  logic [W-1:0] sum2;
  logic [W-1:0] abSum;

  // Sums wrap at W bits before rotating; B's rotate amount comes from A'+B
  always_comb begin
    sum1  = sIn + aIn + bIn;
    aOut  = W'(rotl(64'(sum1), 64'd3, W));
    abSum = aOut + bIn;
    sum2  = lIn + aOut + bIn;
    bOut  = W'(rotl(64'(sum2), 64'(abSum), W));
  end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5 key schedule: fills S with the P/Q progression, then mixes the
// latched key words into it for 3*max(T,C) steps and presents the table.
module rc5_key_expand
  import rc5_pkg::*;
#(
  parameter int W = 32,
  parameter int T = 26,
  parameter int C = 4
) (
  input logic             clk,
  input logic             reset,
  rc5_key_expand_if.slave bus
);

  localparam int IW    = (T > 1) ? $clog2(T) : 1;
  localparam int JW    = (C > 1) ? $clog2(C) : 1;
  localparam int MAXTC = (T > C) ? T : C;

  localparam logic [W-1:0]  PW      = W'(pConst(W));
  localparam logic [W-1:0]  QW      = W'(qConst(W));
  localparam logic [IW-1:0] ILAST   = IW'(T - 1);
  localparam logic [JW-1:0] JLAST   = JW'(C - 1);
  localparam logic [15:0]   MIXLAST = 16'(3 * MAXTC - 1);

  if (!(W == 16 || W == 32 || W == 64)) begin : gBadW
    $fatal(1, "rc5_key_expand: W must be 16, 32 or 64");
  end
  if (T < 2 || T > 255) begin : gBadT
    $fatal(1, "rc5_key_expand: T must be in 2..255");
  end
  if (C < 1 || C > 64) begin : gBadC
    $fatal(1, "rc5_key_expand: C must be in 1..64");
  end

  rc5State_e     state;
  logic [W-1:0]  sMem [T];
  logic [W-1:0]  lMem [C];
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [IW-1:0] i;
  logic [IW-1:0] prevI;
  logic [JW-1:0] j;
  logic [15:0]   mixCnt;
  logic          busyR;
  logic          doneR;
  logic          validR;
  logic [W-1:0]  aNext;
  logic [W-1:0]  bNext;

  // During INIT each word is built from its already-written predecessor
  assign prevI = (i == '0) ? '0 : i - IW'(1);

  rc5_mix_step #(.W(W)) uMix (
    .aIn  (a),
    .bIn  (b),
    .sIn  (sMem[i]),
    .lIn  (lMem[j]),
    .aOut (aNext),
    .bOut (bNext)
  );

  // Controller and table storage; done/busy/s_valid are registered here too
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busyR  <= 1'b0;
      doneR  <= 1'b0;
      validR <= 1'b0;
      a      <= '0;
      b      <= '0;
      i      <= '0;
      j      <= '0;
      mixCnt <= '0;
      for (int k = 0; k < T; k++) sMem[k] <= '0;
      for (int k = 0; k < C; k++) lMem[k] <= '0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < C; k++) lMem[k] <= bus.key[k*W +: W];
            a      <= '0;
            b      <= '0;
            i      <= '0;
            j      <= '0;
            mixCnt <= '0;
            validR <= 1'b0;
            busyR  <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          sMem[i] <= (i == '0) ? PW : sMem[prevI] + QW;
          if (i == ILAST) begin
            i      <= '0;
            mixCnt <= '0;
            state  <= MIX;
          end else begin
            i <= i + IW'(1);
          end
        end
        MIX: begin
          sMem[i] <= aNext;
          lMem[j] <= bNext;
          a       <= aNext;
          b       <= bNext;
          i       <= (i == ILAST) ? '0 : i + IW'(1);
          j       <= (j == JLAST) ? '0 : j + JW'(1);
          if (mixCnt == MIXLAST) begin
            busyR <= 1'b0;
            state <= DONE;
          end else begin
            mixCnt <= mixCnt + 16'd1;
          end
        end
        DONE: begin
          doneR  <= 1'b1;
          validR <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busyR;
  assign bus.done    = doneR;
  assign bus.s_valid = validR;

  for (genvar k = 0; k < T; k++) begin : gOut
    assign bus.s_out[k*W +: W] = sMem[k];
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Bench for rc5_key_expand: four parameterisations driven with directed and
// random keys, checked every cycle against a plain-arithmetic RC5 model.
module tb_rc5_key_expand;

  localparam int NDUT = 4;
  localparam int MAXT = 26;
  localparam int MAXC = 6;

  int cfgW [NDUT] = '{32, 32, 16, 64};
  int cfgT [NDUT] = '{26,  4, 26, 26};
  int cfgC [NDUT] = '{ 4,  6,  4,  4};

  logic clk;
  logic reset;

  logic        startV [NDUT];
  logic [63:0] keyV   [NDUT][MAXC];
  logic        busyV  [NDUT];
  logic        doneV  [NDUT];
  logic        validV [NDUT];
  logic [63:0] sWord  [NDUT][MAXT];

  int checks = 0;
  int fails  = 0;

  rc5_key_expand_if #(.W(32), .T(26), .C(4)) if0 ();
  rc5_key_expand_if #(.W(32), .T(4),  .C(6)) if1 ();
  rc5_key_expand_if #(.W(16), .T(26), .C(4)) if2 ();
  rc5_key_expand_if #(.W(64), .T(26), .C(4)) if3 ();

  rc5_key_expand #(.W(32), .T(26), .C(4)) u0 (.clk(clk), .reset(reset), .bus(if0));
  rc5_key_expand #(.W(32), .T(4),  .C(6)) u1 (.clk(clk), .reset(reset), .bus(if1));
  rc5_key_expand #(.W(16), .T(26), .C(4)) u2 (.clk(clk), .reset(reset), .bus(if2));
  rc5_key_expand #(.W(64), .T(26), .C(4)) u3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the generic per-DUT arrays onto each differently-sized interface
  always_comb begin
    if0.start = startV[0];
    if1.start = startV[1];
    if2.start = startV[2];
    if3.start = startV[3];
    if0.key = '0;
    if1.key = '0;
    if2.key = '0;
    if3.key = '0;
    for (int k = 0; k < 4; k++) if0.key[k*32 +: 32] = keyV[0][k][31:0];
    for (int k = 0; k < 6; k++) if1.key[k*32 +: 32] = keyV[1][k][31:0];
    for (int k = 0; k < 4; k++) if2.key[k*16 +: 16] = keyV[2][k][15:0];
    for (int k = 0; k < 4; k++) if3.key[k*64 +: 64] = keyV[3][k];
    busyV[0] = if0.busy;    busyV[1] = if1.busy;    busyV[2] = if2.busy;    busyV[3] = if3.busy;
    doneV[0] = if0.done;    doneV[1] = if1.done;    doneV[2] = if2.done;    doneV[3] = if3.done;
    validV[0] = if0.s_valid; validV[1] = if1.s_valid; validV[2] = if2.s_valid; validV[3] = if3.s_valid;
    for (int d = 0; d < NDUT; d++)
      for (int k = 0; k < MAXT; k++) sWord[d][k] = '0;
    for (int k = 0; k < 26; k++) sWord[0][k] = 64'(if0.s_out[k*32 +: 32]);
    for (int k = 0; k < 4;  k++) sWord[1][k] = 64'(if1.s_out[k*32 +: 32]);
    for (int k = 0; k < 26; k++) sWord[2][k] = 64'(if2.s_out[k*16 +: 16]);
    for (int k = 0; k < 26; k++) sWord[3][k] = 64'(if3.s_out[k*64 +: 64]);
  end

  function automatic logic [63:0] maskOf(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] x, input int r, input int w);
    logic [63:0] m;
    int          s;
    m = maskOf(w);
    s = r % w;
    if (s == 0) return x & m;
    return ((x << s) | (x >> (w - s))) & m;
  endfunction

  function automatic int maxOf(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Textbook RC5 key schedule, stopped after nMix mixing steps
  function automatic void expandModel(input int w, input int t, input int c,
                                      input logic [63:0] keyIn [MAXC], input int nMix,
                                      output logic [63:0] sRes [MAXT]);
    logic [63:0] m, p, q, av, bv;
    logic [63:0] l [MAXC];
    int          ii, jj;
    m = maskOf(w);
    case (w)
      16:      begin p = 64'hB7E1;     q = 64'h9E37;     end
      32:      begin p = 64'hB7E15163; q = 64'h9E3779B9; end
      default: begin p = 64'hB7E151628AED2A6B; q = 64'h9E3779B97F4A7C15; end
    endcase
    for (int k = 0; k < MAXT; k++) sRes[k] = '0;
    sRes[0] = p;
    for (int k = 1; k < t; k++) sRes[k] = (sRes[k-1] + q) & m;
    for (int k = 0; k < MAXC; k++) l[k] = keyIn[k] & m;
    av = '0; bv = '0; ii = 0; jj = 0;
    for (int n = 0; n < nMix; n++) begin
      av = rol((sRes[ii] + av + bv) & m, 3, w);
      bv = rol((l[jj] + av + bv) & m, int'(((av + bv) & m) % 64'(w)), w);
      sRes[ii] = av;
      l[jj]    = bv;
      ii = (ii + 1) % t;
      jj = (jj + 1) % c;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  bit          modelOn = 0;
  bit          mActive  [NDUT];
  int          mK       [NDUT];
  bit          expBusy  [NDUT];
  bit          expDone  [NDUT];
  bit          expValid [NDUT];
  bit          expZero  [NDUT];
  logic [63:0] keyLatch [NDUT][MAXC];
  logic [63:0] expS     [NDUT][MAXT];

  // Reference behaviour: count edges since the accepted start, build the table at the end
  always @(posedge clk) begin
    logic [63:0] tk [MAXC];
    logic [63:0] ts [MAXT];
    int          n;
    if (reset) modelOn = 1;
    for (int d = 0; d < NDUT; d++) begin
      n = cfgT[d] + 3 * maxOf(cfgT[d], cfgC[d]);
      if (reset) begin
        mActive[d] = 0; mK[d] = 0; expBusy[d] = 0; expDone[d] = 0;
        expValid[d] = 0; expZero[d] = 1;
      end else begin
        expDone[d] = 0;
        if (!mActive[d]) begin
          if (startV[d]) begin
            mActive[d] = 1; mK[d] = 0; expBusy[d] = 1; expValid[d] = 0; expZero[d] = 0;
            for (int k = 0; k < MAXC; k++) keyLatch[d][k] = keyV[d][k];
          end
        end else begin
          mK[d]++;
          if (mK[d] == n) expBusy[d] = 0;
          if (mK[d] == n + 1) begin
            expDone[d] = 1; expValid[d] = 1; mActive[d] = 0;
            for (int k = 0; k < MAXC; k++) tk[k] = keyLatch[d][k];
            expandModel(cfgW[d], cfgT[d], cfgC[d], tk, 3 * maxOf(cfgT[d], cfgC[d]), ts);
            for (int k = 0; k < MAXT; k++) expS[d][k] = ts[k];
          end
        end
      end
    end
  end

  // Every cycle: control outputs always, the table whenever it is defined
  always @(negedge clk) begin
    int          bad;
    logic [63:0] want;
    if (modelOn) begin
      for (int d = 0; d < NDUT; d++) begin
        checkOutput($sformatf("d%0d busy/done/valid", d),
                    {61'd0, busyV[d], doneV[d], validV[d]},
                    {61'd0, expBusy[d], expDone[d], expValid[d]});
        if (expValid[d] || expZero[d]) begin
          bad = -1;
          for (int k = 0; k < cfgT[d]; k++) begin
            want = expZero[d] ? 64'd0 : expS[d][k];
            if (sWord[d][k] !== want && bad < 0) bad = k;
          end
          if (bad < 0) bad = 0;
          checkOutput($sformatf("d%0d s_out word %0d", d, bad), sWord[d][bad],
                      expZero[d] ? 64'd0 : expS[d][bad]);
        end
      end
    end
  end

  task automatic randomKey(input int d);
    for (int k = 0; k < MAXC; k++)
      keyV[d][k] = {$urandom, $urandom} & maskOf(cfgW[d]);
  endtask

  // One expansion on DUT d; optionally a stray start pulse at cycle pokeAt
  task automatic applyStimulus(input int d, input bit zeroKey, input int pokeAt);
    int n, doneAt, busyCnt;
    n = cfgT[d] + 3 * maxOf(cfgT[d], cfgC[d]);
    if (zeroKey) begin
      for (int k = 0; k < MAXC; k++) keyV[d][k] = '0;
    end else begin
      randomKey(d);
    end
    startV[d] = 1'b1;
    @(negedge clk);
    startV[d] = 1'b0;
    randomKey(d);
    busyCnt = busyV[d] ? 1 : 0;
    doneAt  = -1;
    for (int cyc = 1; cyc <= n + 20; cyc++) begin
      @(negedge clk);
      if (cyc == pokeAt)     startV[d] = 1'b1;
      if (cyc == pokeAt + 1) startV[d] = 1'b0;
      if (zeroKey && d == 0 && cyc == cfgT[d]) begin
        checkOutput("zero key S[0] after INIT", sWord[0][0], 64'hB7E15163);
        checkOutput("zero key S[1] after INIT", sWord[0][1], 64'h5618CB1C);
        checkOutput("zero key S[2] after INIT", sWord[0][2], 64'hF45044D5);
      end
      if (zeroKey && d == 0 && cyc == cfgT[d] + 1)
        checkOutput("zero key S[0] after first MIX step", sWord[0][0], 64'hBF0A8B1D);
      if (busyV[d]) busyCnt++;
      if (doneV[d]) begin
        doneAt = cyc;
        break;
      end
    end
    startV[d] = 1'b0;
    checkOutput($sformatf("d%0d done edge", d), 64'(doneAt), 64'(n + 1));
    checkOutput($sformatf("d%0d busy cycles", d), 64'(busyCnt), 64'(n));
  endtask

  initial begin
    logic [63:0] zk [MAXC];
    logic [63:0] ms [MAXT];
    int          n0;
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      startV[d] = 1'b0;
      for (int k = 0; k < MAXC; k++) keyV[d][k] = '0;
    end
    for (int k = 0; k < MAXC; k++) zk[k] = '0;

    // Pin the model itself with hand-computed values
    expandModel(32, 26, 4, zk, 0, ms);
    checkOutput("model S[0] init", ms[0], 64'hB7E15163);
    checkOutput("model S[1] init", ms[1], 64'h5618CB1C);
    checkOutput("model S[2] init", ms[2], 64'hF45044D5);
    expandModel(32, 26, 4, zk, 1, ms);
    checkOutput("model S[0] first step", ms[0], 64'hBF0A8B1D);
    expandModel(16, 26, 4, zk, 0, ms);
    checkOutput("model W16 S[1] init", ms[1], 64'h5618);

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busyV[0]), 64'd0);
    checkOutput("reset s_valid", 64'(validV[0]), 64'd0);
    checkOutput("reset s_out word 0", sWord[0][0], 64'd0);

    $display("[TB] zero-key run starting on the first edge without reset");
    reset = 1'b0;
    applyStimulus(0, 1'b1, 0);

    $display("[TB] stray start during MIX");
    applyStimulus(0, 1'b0, 50);
    repeat (20) @(negedge clk);
    checkOutput("stray start not queued", 64'(busyV[0]), 64'd0);

    $display("[TB] start held high");
    n0 = 26 + 3 * 26;
    for (int c = 0; c < 2 * n0 + 4; c++) begin
      randomKey(0);
      startV[0] = 1'b1;
      @(negedge clk);
    end
    startV[0] = 1'b0;
    repeat (2 * n0 + 10) @(negedge clk);

    $display("[TB] reset in the middle of MIX");
    randomKey(0);
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-MIX reset busy", 64'(busyV[0]), 64'd0);
    checkOutput("mid-MIX reset done", 64'(doneV[0]), 64'd0);
    checkOutput("mid-MIX reset s_valid", 64'(validV[0]), 64'd0);
    checkOutput("mid-MIX reset s_out word 5", sWord[0][5], 64'd0);
    reset = 1'b0;
    applyStimulus(0, 1'b0, 0);

    $display("[TB] random keys, C larger than T");
    repeat (20) applyStimulus(1, 1'b0, 0);
    $display("[TB] random keys, W=16");
    repeat (50) applyStimulus(2, 1'b0, 0);
    $display("[TB] random keys, W=64");
    repeat (50) applyStimulus(3, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
